// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants and helpers for the MIPS datapath blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int REG_ZERO  = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module : reg_scoreboard
// Brief  : Per-register write-pending bits, pending count and double-issue flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      pend_cnt,
    output logic             dbl_iss
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      r_pend_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             r_dbl_iss;
    logic             w_iss_ok;
    logic             w_dbl_set;

    assign w_iss_ok  = iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO)));
    assign w_dbl_set = w_iss_ok && r_busy[iss_addr] && !(wr_en && (wr_addr == iss_addr));

    // Clear is applied before set so a same-cycle issue keeps the bit busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
        w_cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_dbl_iss  <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_cnt_nxt;
            if (w_dbl_set) begin
                r_dbl_iss <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign pend_cnt = r_pend_cnt;
    assign dbl_iss  = r_dbl_iss;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module : reg_file_sb
// Brief  : Multi-port register file with write bypass and write-pending scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import mips_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NREAD    = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic [AW:0]            pend_cnt,
    output logic                   dbl_iss
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_busy;
    logic             w_wr_ok;

    assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == AW'(REG_ZERO)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (w_busy),
        .pend_cnt (pend_cnt),
        .dbl_iss  (dbl_iss)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd_port
        logic [AW-1:0] w_addr;
        logic          w_is_zero;
        logic          w_wr_hit;

        assign w_addr    = rd_addr[i*AW +: AW];
        assign w_is_zero = (ZERO_REG != 0) && (w_addr == AW'(REG_ZERO));
        assign w_wr_hit  = wr_en && (wr_addr == w_addr);

        assign rd_data[i*WIDTH +: WIDTH] = w_is_zero ? '0 :
                                           w_wr_hit  ? wr_data : r_mem[w_addr];
        // A writeback in the same cycle satisfies the pending hazard.
        assign rd_busy[i] = w_busy[w_addr] && !w_wr_hit;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module : tb_reg_file_sb
// Brief  : Scoreboard-driven checks of reg_file_sb, default and 3-port/16-entry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  pend_cnt;
    logic        dbl_iss;

    logic [11:0] rd_addr3;
    logic [47:0] rd_data3;
    logic [2:0]  rd_busy3;
    logic        wr_en3;
    logic [3:0]  wr_addr3;
    logic [15:0] wr_data3;
    logic        iss_en3;
    logic [3:0]  iss_addr3;
    logic [4:0]  pend_cnt3;
    logic        dbl_iss3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];

    reg_file_sb u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_cnt (pend_cnt),
        .dbl_iss  (dbl_iss)
    );

    reg_file_sb #(
        .WIDTH (16),
        .DEPTH (16),
        .NREAD (3)
    ) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr3),
        .rd_data  (rd_data3),
        .rd_busy  (rd_busy3),
        .wr_en    (wr_en3),
        .wr_addr  (wr_addr3),
        .wr_data  (wr_data3),
        .iss_en   (iss_en3),
        .iss_addr (iss_addr3),
        .pend_cnt (pend_cnt3),
        .dbl_iss  (dbl_iss3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return rd_data[31:0];
            1:       return rd_data[63:32];
            2:       return {31'd0, rd_busy[0]};
            3:       return {31'd0, rd_busy[1]};
            4:       return {26'd0, pend_cnt};
            5:       return {31'd0, dbl_iss};
            6:       return {16'd0, rd_data3[15:0]};
            7:       return {16'd0, rd_data3[31:16]};
            8:       return {16'd0, rd_data3[47:32]};
            9:       return {27'd0, pend_cnt3};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr3 = '0;
        wr_en3   = 1'b0;
        wr_addr3 = '0;
        wr_data3 = '0;
        iss_en3  = 1'b0;
        iss_addr3 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state across all registers on both ports.
        expect_val("rst_pend", 4, 32'd0);
        expect_val("rst_dbl", 5, 32'd0);
        drain();
        for (int r = 0; r < 32; r++) begin
            rd_addr = {r[4:0], r[4:0]};
            #1;
            expect_val($sformatf("rst_p0_r%0d", r), 0, 32'd0);
            expect_val($sformatf("rst_p1_r%0d", r), 1, 32'd0);
            expect_val($sformatf("rst_busy_r%0d", r), 2, 32'd0);
            drain();
        end

        // Bypass then storage for r8.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
        rd_addr = {5'd0, 5'd8};
        #1;
        expect_val("byp_r8", 0, 32'hDEAD_BEEF);
        expect_val("byp_p1_r0", 1, 32'd0);
        drain();
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("stor_r8", 0, 32'hDEAD_BEEF);
        drain();

        // Writes to r0 are dropped and never bypassed.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5555_5555;
        rd_addr = {5'd8, 5'd0};
        #1;
        expect_val("r0_byp", 0, 32'd0);
        expect_val("r8_p1", 1, 32'hDEAD_BEEF);
        drain();
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("r0_stor", 0, 32'd0);
        drain();

        // Issue r9, then writeback clears it.
        iss_en = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd9, 5'd9};
        #1;
        expect_val("r9_busy_pre", 2, 32'd0);
        drain();
        tick();
        iss_en = 1'b0;
        #1;
        expect_val("r9_busy_p0", 2, 32'd1);
        expect_val("r9_busy_p1", 3, 32'd1);
        expect_val("r9_pend", 4, 32'd1);
        drain();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_1234;
        #1;
        expect_val("r9_busy_wb", 2, 32'd0);
        expect_val("r9_byp", 0, 32'h0000_1234);
        expect_val("r9_pend_wb", 4, 32'd1);
        drain();
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("r9_pend_post", 4, 32'd0);
        expect_val("r9_busy_post", 2, 32'd0);
        expect_val("r9_stor", 0, 32'h0000_1234);
        drain();

        // Simultaneous issue and writeback to a busy r10.
        iss_en = 1'b1; iss_addr = 5'd10;
        rd_addr = {5'd10, 5'd10};
        tick();
        iss_en = 1'b1; iss_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_AAAA;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        expect_val("r10_busy", 2, 32'd1);
        expect_val("r10_pend", 4, 32'd1);
        expect_val("r10_dbl", 5, 32'd0);
        expect_val("r10_data", 1, 32'h0000_AAAA);
        drain();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_BBBB;
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("r10_pend_clr", 4, 32'd0);
        drain();

        // Double issue to r11 sets the sticky flag.
        iss_en = 1'b1; iss_addr = 5'd11;
        rd_addr = {5'd11, 5'd11};
        tick();
        expect_val("r11_dbl_first", 5, 32'd0);
        drain();
        tick();
        iss_en = 1'b0;
        #1;
        expect_val("r11_dbl", 5, 32'd1);
        expect_val("r11_pend", 4, 32'd1);
        drain();
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h0000_0011;
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        expect_val("r11_dbl_sticky", 5, 32'd1);
        expect_val("r11_pend_clr", 4, 32'd0);
        drain();

        // Async reset mid-cycle with r5 busy.
        iss_en = 1'b1; iss_addr = 5'd5;
        rd_addr = {5'd8, 5'd5};
        tick();
        iss_en = 1'b0;
        #1;
        expect_val("r5_busy", 2, 32'd1);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        expect_val("arst_busy", 2, 32'd0);
        expect_val("arst_pend", 4, 32'd0);
        expect_val("arst_dbl", 5, 32'd0);
        expect_val("arst_r8", 1, 32'd0);
        drain();
        tick();
        #2;
        rst_n = 1'b1;
        tick();

        // Three-port 16-entry instance.
        wr_en3 = 1'b1; wr_addr3 = 4'd3; wr_data3 = 16'h1111;
        tick();
        wr_addr3 = 4'd15; wr_data3 = 16'hBEEF;
        tick();
        wr_en3 = 1'b0;
        rd_addr3 = {4'd15, 4'd3, 4'd3};
        #1;
        expect_val("n3_p0_r3", 6, 32'h0000_1111);
        expect_val("n3_p1_r3", 7, 32'h0000_1111);
        expect_val("n3_p2_r15", 8, 32'h0000_BEEF);
        drain();
        for (int r = 1; r < 16; r++) begin
            iss_en3 = 1'b1; iss_addr3 = r[3:0];
            tick();
        end
        iss_en3 = 1'b1; iss_addr3 = 4'd0;
        tick();
        iss_en3 = 1'b0;
        #1;
        expect_val("n3_pend15", 9, 32'd15);
        drain();
        wr_en3 = 1'b1; wr_addr3 = 4'd15; wr_data3 = 16'h0F0F;
        tick();
        wr_en3 = 1'b0;
        #1;
        expect_val("n3_pend14", 9, 32'd14);
        expect_val("n3_p2_r15_wb", 8, 32'h0000_0F0F);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated write-pending scoreboard for the MIPS datapath. Provides NREAD combinational read ports with write-to-read bypass, one synchronous write port, a hardwired zero register, and per-register busy bits. Busy bits are set when a multicycle producer issues and cleared on its writeback. Sits between decode and the ALU/data-memory writeback path, and replaces the unreset, single-read-address register file used so far.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; power of two, at least 2
- NREAD, 2, number of read ports, at least 1
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and issues
- AW, localparam clog2(DEPTH), register address width
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*AW  packed read addresses; port i is [i*AW +: AW]
- rd_data  out  NREAD*WIDTH  packed read data, combinational
- rd_busy  out  NREAD  port i's register has a pending write not satisfied this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  WIDTH  writeback value
- iss_en  in  1  a multicycle producer issues this cycle
- iss_addr  in  AW  destination of the issuing producer
- pend_cnt  out  AW+1  number of registers currently busy
- dbl_iss  out  1  sticky error flag: issue to an already-busy register with no same-cycle writeback to it

## Operation
- Reset, asynchronous on rst_n low:
  - every register, every busy bit, pend_cnt and dbl_iss go to 0 immediately.
  - An in-flight scoreboard state is discarded.
  - A writeback arriving after reset is treated as an ordinary write.
- Write:
  - At posedge with wr_en=1, reg[wr_addr] <= wr_data.
  - When ZERO_REG=1 and wr_addr=0, the write is dropped.
  - A write to a non-busy register is legal (single-cycle ops).
- Read, combinational per port:
  - When wr_en=1, rd_addr[i]=wr_addr and the address is not the zero register, rd_data[i]=wr_data (bypass).
  - Otherwise rd_data[i]=reg[rd_addr[i]].
  - When ZERO_REG=1 and rd_addr[i]=0, rd_data[i]=0 always.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (wr_en AND wr_addr=rd_addr[i]).
  - A same-cycle writeback resolves the hazard.
  - Register 0 is never busy when ZERO_REG=1.
- Scoreboard, evaluated at posedge; per register r, with S = iss_en AND iss_addr=r and C = wr_en AND wr_addr=r:
  - S=1: busy[r] <= 1. Issue wins over a simultaneous clear, since the new producer is the youngest.
  - S=0, C=1: busy[r] <= 0.
  - Otherwise busy[r] holds.
  - Issue to register 0 with ZERO_REG=1 is ignored.
- pend_cnt equals the population count of busy after each edge. It is registered and updated at the same edge as busy.
- dbl_iss:
  - Set at posedge when iss_en=1, busy[iss_addr]=1 and NOT (wr_en AND wr_addr=iss_addr).
  - Cleared only by reset.
  - The issue itself still takes effect.

## Timing
- Read latency 0: rd_data and rd_busy are combinational from rd_addr, wr_*, and the register/busy state.
- Write latency 1: the value is visible through storage from the cycle after wr_en; through bypass in the same cycle.
- Busy set latency 1: rd_busy reads 1 starting the cycle after iss_en.
- Busy clear is visible combinationally in the writeback cycle and from storage thereafter.
- pend_cnt and dbl_iss change only at posedge or on asynchronous reset.
- No read-port count limit on the same address: all ports may alias freely.

## Structure
- Shared package mips_pkg holds:
  - REG_ZERO address constant;
  - default WIDTH/DEPTH;
  - a clog2 function used for AW.
- One sub-module, reg_scoreboard, owns the busy vector, pend_cnt and dbl_iss (ports clk, rst_n, iss_*, wr_en, wr_addr).
- The storage array and read muxes stay in reg_file_sb, generated over NREAD.

## Test plan
- Reset, then read all 32 registers on both ports: expect 0, pend_cnt=0, dbl_iss=0. Assert rst_n low mid-run with busy[5]=1: busy clears without waiting for a clock edge.
- Write 0xDEADBEEF to r8 while port0 reads r8 in the same cycle: port0 shows 0xDEADBEEF that cycle, and the next cycle from storage. Write to r0: reads stay 0.
- Issue r9: the next cycle, rd_busy for r9 is 1 and pend_cnt=1. Writeback r9=0x1234: rd_busy drops in that cycle and pend_cnt=0 after the edge.
- Same-cycle issue and writeback to r10 (r10 busy beforehand): busy stays 1, pend_cnt unchanged, dbl_iss stays 0.
- Issue r11 twice with no writeback in between: dbl_iss=1 after the second edge and stays 1 until reset.
- NREAD=3, DEPTH=16, WIDTH=16 instance: three ports reading r3/r3/r15 return the correct values. Issuing r1–r15 yields pend_cnt=15, with no overflow of the AW+1-bit counter.
